spi_axis_bridge: RTL and testbench

- SPI slave (mode 0, MSB first) that turns bytes from the host processor into an 8-bit AXI-Stream feeding the Wishbone-master command stage.
- Returns that stage's response stream to the host on MISO.
- Frame = one CS_n low period. The last byte of a frame carries tlast.
- SPI pins are oversampled in the i_clk domain; no second clock.

---
 rtl/spi_axis_bridge_if.sv | 21 ++
 rtl/spi_axis_bridge.sv | 181 ++++++++++++++++++
 tb/tb_spi_axis_bridge.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_axis_bridge_if.sv
// AXI-Stream pair between the SPI bridge and the Wishbone-master command stage.
// master: bridge side (drives the RX stream, accepts the response stream).
interface spi_axis_bridge_if;
   logic [7:0] o_axis_tdata;
   logic       o_axis_tvalid;
   logic       o_axis_tready;
   logic       o_axis_tlast;
   logic [7:0] i_axis_tdata;
   logic       i_axis_tvalid;
   logic       i_axis_tready;

   modport master (
      output o_axis_tdata, o_axis_tvalid, o_axis_tlast, i_axis_tready,
      input  o_axis_tready, i_axis_tdata, i_axis_tvalid
   );

   modport slave (
      input  o_axis_tdata, o_axis_tvalid, o_axis_tlast, i_axis_tready,
      output o_axis_tready, i_axis_tdata, i_axis_tvalid
   );
endinterface

// File: rtl/spi_axis_bridge.sv
// SPI mode-0 slave oversampled in i_clk: MOSI bytes -> AXIS with FWFT FIFO, response AXIS -> MISO.
// Optional macro SPI_AXIS_FRAME_STATS_EN adds o_frame_count / o_abort_count.
module spi_axis_bridge #(
   parameter int unsigned FIFO_AW     = 4,
   parameter logic [7:0]  FILL_BYTE   = 8'hFF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_spi_sclk,
   input  logic i_spi_cs_n,
   input  logic i_spi_mosi,
   output logic o_spi_miso,
   output logic o_spi_miso_oe,
   spi_axis_bridge_if.master axis,
   output logic o_overrun,
   output logic o_busy
`ifdef SPI_AXIS_FRAME_STATS_EN
   ,
   output logic [15:0] o_frame_count,
   output logic [7:0]  o_abort_count
`endif
);

   localparam int unsigned DEPTH   = 1 << FIFO_AW;
   localparam int unsigned FLUSH   = SYNC_STAGES + 1;
   localparam int unsigned FLUSH_W = $clog2(FLUSH + 1);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_prev, cs_prev;
   logic [FLUSH_W-1:0]     flush_cnt;
   logic                   sclk_s, cs_s, mosi_s, sync_ok;

   logic [2:0] bit_cnt;
   logic [7:0] rx_shift, tx_shift, pend, rx_byte;
   logic       pend_valid;

   logic active, cs_fall, sclk_rise, sclk_fall, byte_done, tx_load;
   logic push_req;
   logic [8:0] push_data;

   logic [8:0]       mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic             empty, full, push, pop;
   logic [8:0]       head;

   // Synchronizers; flush_cnt keeps the reset idle levels from looking like a CS fall.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
         flush_cnt <= '0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
         if (flush_cnt != FLUSH_W'(FLUSH)) flush_cnt <= flush_cnt + FLUSH_W'(1);
      end
   end

   assign sclk_s  = sclk_sync[SYNC_STAGES-1];
   assign cs_s    = cs_sync[SYNC_STAGES-1];
   assign mosi_s  = mosi_sync[SYNC_STAGES-1];
   assign sync_ok = (flush_cnt == FLUSH_W'(FLUSH));

   assign active    = (state == ST_ACTIVE) && !cs_s;
   assign cs_fall   = (state == ST_IDLE) && sync_ok && cs_prev && !cs_s;
   assign sclk_rise = active && sclk_s && !sclk_prev;
   assign sclk_fall = active && !sclk_s && sclk_prev;
   assign byte_done = sclk_rise && (bit_cnt == 3'd7);
   assign tx_load   = cs_fall || (sclk_fall && (bit_cnt == 3'd0));
   assign rx_byte   = {rx_shift[6:0], mosi_s};

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_next;
   end

   // Frame FSM; the pending byte is pushed one byte late so CS rise can mark it tlast.
   always_comb begin
      state_next = state;
      push_req   = 1'b0;
      push_data  = '0;
      case (state)
         ST_IDLE: begin
            if (cs_fall) state_next = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (cs_s) begin
               state_next = ST_IDLE;
               push_req   = pend_valid;
               push_data  = {1'b1, pend};
            end else if (byte_done) begin
               push_req  = pend_valid;
               push_data = {1'b0, pend};
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         bit_cnt    <= '0;
         rx_shift   <= '0;
         tx_shift   <= FILL_BYTE;
         pend       <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (!active) begin
            bit_cnt <= '0;
         end else if (sclk_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= rx_byte;
            if (byte_done) begin
               pend       <= rx_byte;
               pend_valid <= 1'b1;
            end
         end
         if (state == ST_ACTIVE && cs_s) pend_valid <= 1'b0;
         // Responses are taken only at byte boundaries so a late byte is never split.
         if (tx_load)        tx_shift <= axis.i_axis_tvalid ? axis.i_axis_tdata : FILL_BYTE;
         else if (sclk_fall) tx_shift <= {tx_shift[6:0], 1'b0};
      end
   end

   assign axis.i_axis_tready = tx_load && axis.i_axis_tvalid;
   assign o_spi_miso         = tx_shift[7];
   assign o_spi_miso_oe      = (state == ST_ACTIVE);

   // RX FIFO, first-word-fall-through; a pop at full frees the slot for a same-cycle push.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign pop   = !empty && axis.o_axis_tready;
   assign push  = push_req && (!full || pop);
   assign head  = mem[rd_ptr[FIFO_AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         o_overrun <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
         if (push_req && full && !pop) o_overrun <= 1'b1;
      end
   end

   assign axis.o_axis_tvalid = !empty;
   assign axis.o_axis_tdata  = empty ? 8'h00 : head[7:0];
   assign axis.o_axis_tlast  = !empty && head[8];
   assign o_busy             = (state == ST_ACTIVE) || !empty;

`ifdef SPI_AXIS_FRAME_STATS_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_frame_count <= '0;
         o_abort_count <= '0;
      end else if (state == ST_ACTIVE && cs_s) begin
         if (pend_valid) o_frame_count <= o_frame_count + 16'd1;
         if (bit_cnt != 3'd0 && o_abort_count != 8'hFF) o_abort_count <= o_abort_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_spi_axis_bridge.sv
// Bench for spi_axis_bridge: table of SPI frames plus hand-written corner sequences,
// AXIS output checked against a scoreboard queue.
module tb_spi_axis_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk = 1'b0;
   logic cs_n = 1'b1;
   logic mosi = 1'b0;
   logic miso, miso_oe, overrun, busy;
`ifdef SPI_AXIS_FRAME_STATS_EN
   logic [15:0] frame_count;
   logic [7:0]  abort_count;
`endif

   spi_axis_bridge_if axis();

   spi_axis_bridge #(.FIFO_AW(4), .FILL_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_spi_sclk    (sclk),
      .i_spi_cs_n    (cs_n),
      .i_spi_mosi    (mosi),
      .o_spi_miso    (miso),
      .o_spi_miso_oe (miso_oe),
      .axis          (axis),
      .o_overrun     (overrun),
      .o_busy        (busy)
`ifdef SPI_AXIS_FRAME_STATS_EN
      ,
      .o_frame_count (frame_count),
      .o_abort_count (abort_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;
   int exp_frames = 0;
   int exp_aborts = 0;
   logic [8:0] sb_q[$];
   logic [7:0] resp_q[$];

   typedef struct {
      int          nbytes;
      logic [31:0] mosi;
      int          nbits;
      int          nresp;
      logic [31:0] resp;
      logic [31:0] miso_exp;
   } vec_t;

   localparam int NV = 5;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_at(input logic [31:0] w, input int k);
      return w[8*(3-k) +: 8];
   endfunction

   // AXIS sink: compare each handshake against the scoreboard head
   always @(negedge clk) begin : mon
      logic [8:0] e;
      if (axis.o_axis_tvalid && axis.o_axis_tready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL axis_unexpected: got %0h expected nothing", {axis.o_axis_tlast, axis.o_axis_tdata});
         end else begin
            e = sb_q.pop_front();
            check("axis_byte", 32'({axis.o_axis_tlast, axis.o_axis_tdata}), 32'(e));
         end
      end
   end

   // Response source: presents resp_q head, pops after an accepted handshake
   always begin : resp_drv
      logic hs;
      @(negedge clk);
      hs = axis.i_axis_tvalid && axis.i_axis_tready;
      if (hs) pulses++;
      @(posedge clk);
      #1;
      if (hs && resp_q.size() > 0) void'(resp_q.pop_front());
      axis.i_axis_tvalid = (resp_q.size() > 0);
      axis.i_axis_tdata  = (resp_q.size() > 0) ? resp_q[0] : 8'h00;
   end

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      clk_wait(8);
      m = miso;
      sclk = 1'b1;
      clk_wait(8);
      sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
      logic bm;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(b[i], bm);
         m[i] = bm;
      end
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      clk_wait(8);
   endtask

   task automatic cs_high();
      clk_wait(8);
      cs_n = 1'b1;
      clk_wait(12);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && sb_q.size() > 0; i++) clk_wait(1);
      check(name, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic check_stats(input string name);
`ifdef SPI_AXIS_FRAME_STATS_EN
      check({name, "_frames"}, 32'(frame_count), 32'(exp_frames));
      check({name, "_aborts"}, 32'(abort_count), 32'(exp_aborts));
`else
      check({name, "_busy"}, 32'(busy), 32'd0);
`endif
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      logic [7:0] got;
      logic       bm;

      vecs[0] = '{3, 32'hA53C0100, 0, 0, 32'h00000000, 32'hFFFFFF00};
      vecs[1] = '{2, 32'h00000000, 0, 2, 32'h12340000, 32'h12340000};
      vecs[2] = '{1, 32'hAA000000, 0, 1, 32'h5A000000, 32'h5A000000};
      vecs[3] = '{2, 32'h817E0000, 3, 0, 32'h00000000, 32'hFFFF0000};
      vecs[4] = '{4, 32'hDEADBEEF, 0, 3, 32'hC300F000, 32'hC300F0FF};

      axis.o_axis_tready = 1'b1;
      axis.i_axis_tvalid = 1'b0;
      axis.i_axis_tdata  = 8'h00;
      clk_wait(5);
      rst = 1'b0;
      clk_wait(6);

      check("rst_tvalid", 32'(axis.o_axis_tvalid), 32'd0);
      check("rst_tdata", 32'(axis.o_axis_tdata), 32'd0);
      check("rst_tlast", 32'(axis.o_axis_tlast), 32'd0);
      check("rst_resp_tready", 32'(axis.i_axis_tready), 32'd0);
      check("rst_miso", 32'(miso), 32'd1);
      check("rst_oe", 32'(miso_oe), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_stats("rst");

      for (int v = 0; v < NV; v++) begin
         vec_t t;
         t = vecs[v];
         for (int k = 0; k < t.nresp; k++) resp_q.push_back(byte_at(t.resp, k));
         clk_wait(4);
         pulses = 0;
         for (int k = 0; k < t.nbytes; k++)
            sb_q.push_back({1'(k == t.nbytes - 1), byte_at(t.mosi, k)});
         cs_low();
         check($sformatf("v%0d_oe", v), 32'(miso_oe), 32'd1);
         for (int k = 0; k < t.nbytes; k++) begin
            spi_byte(byte_at(t.mosi, k), got);
            check($sformatf("v%0d_miso%0d", v, k), 32'(got), 32'(byte_at(t.miso_exp, k)));
         end
         for (int b = 0; b < t.nbits; b++) spi_bit(1'b1, bm);
         cs_high();
         wait_drain($sformatf("v%0d_drain", v));
         check($sformatf("v%0d_resp_pulses", v), 32'(pulses), 32'(t.nresp));
         check($sformatf("v%0d_oe_off", v), 32'(miso_oe), 32'd0);
         check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
         check($sformatf("v%0d_overrun", v), 32'(overrun), 32'd0);
         if (t.nbytes > 0) exp_frames++;
         if (t.nbits > 0) exp_aborts++;
         check_stats($sformatf("v%0d", v));
      end

      // 8 full bytes of FF then 3 stray bits
      for (int k = 0; k < 8; k++) sb_q.push_back({1'(k == 7), 8'hFF});
      cs_low();
      for (int k = 0; k < 8; k++) spi_byte(8'hFF, got);
      for (int b = 0; b < 3; b++) spi_bit(1'b1, bm);
      cs_high();
      wait_drain("partial_drain");
      exp_frames++;
      exp_aborts++;
      check_stats("partial");

      // 17 bytes into a 16-entry FIFO with the sink stalled
      axis.o_axis_tready = 1'b0;
      cs_low();
      for (int k = 0; k < 17; k++) spi_byte(8'(k + 1), got);
      cs_high();
      check("ovr_overrun", 32'(overrun), 32'd1);
      check("ovr_tvalid", 32'(axis.o_axis_tvalid), 32'd1);
      check("ovr_head", 32'(axis.o_axis_tdata), 32'h01);
      check("ovr_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 16; k++) sb_q.push_back({1'b0, 8'(k + 1)});
      axis.o_axis_tready = 1'b1;
      wait_drain("ovr_drain");
      check("ovr_empty", 32'(axis.o_axis_tvalid), 32'd0);
      check("ovr_sticky", 32'(overrun), 32'd1);
      exp_frames++;
      check_stats("ovr");

      // reset four bits into byte 2; rest of this CS-low period must be ignored
      cs_low();
      spi_byte(8'h11, got);
      for (int b = 0; b < 4; b++) spi_bit(1'b1, bm);
      rst = 1'b1;
      clk_wait(2);
      rst = 1'b0;
      clk_wait(6);
      exp_frames = 0;
      exp_aborts = 0;
      check("mid_rst_tvalid", 32'(axis.o_axis_tvalid), 32'd0);
      check("mid_rst_overrun", 32'(overrun), 32'd0);
      check("mid_rst_oe", 32'(miso_oe), 32'd0);
      check("mid_rst_miso", 32'(miso), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      for (int b = 0; b < 4; b++) spi_bit(1'b0, bm);
      spi_byte(8'h55, got);
      check("mid_rst_still_off", 32'(miso_oe), 32'd0);
      cs_high();
      check("mid_rst_no_push", 32'(axis.o_axis_tvalid), 32'd0);
      check_stats("mid_rst");
      sb_q.push_back({1'b1, 8'hAA});
      cs_low();
      spi_byte(8'hAA, got);
      cs_high();
      wait_drain("after_rst_drain");
      exp_frames++;
      check_stats("after_rst");

      // CS pulse with no clocks
      cs_low();
      clk_wait(10);
      check("pulse_oe_on", 32'(miso_oe), 32'd1);
      check("pulse_tvalid_low", 32'(axis.o_axis_tvalid), 32'd0);
      cs_n = 1'b1;
      clk_wait(10);
      check("pulse_oe_off", 32'(miso_oe), 32'd0);
      check("pulse_tvalid_after", 32'(axis.o_axis_tvalid), 32'd0);
      check("pulse_busy", 32'(busy), 32'd0);
      check_stats("pulse");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
